// File: rtl/isdu_fetch_ctrl.sv
// isdu_fetch_ctrl
// Instruction fetch sequencer for the LC-3b datapath. It walks the datapath
// through MAR<-PC / PC<-PC+1, an SRAM read into MDR and IR<-MDR. It then
// waits for the operator. One instruction is fetched per Run start or
// Continue press.
//
// Ports
//   Clk        system clock, rising edge
//   Reset      asynchronous, active-high; forces HALTED and idle outputs
//   Run        level; leaves HALTED
//   Continue   level; one fetch per press (rise then fall) while paused
//   load_mar / load_pc / load_mdr / load_ir   datapath register loads
//   GatePC / GateMDR                          data-bus tri-state gates
//   Mem_CE / Mem_OE / Mem_WE                  SRAM strobes, active-low
//   state_dbg  current state encoding for the hex display
//
// Parameter
//   MEM_WAIT   cycles Mem_OE is held low before MDR captures (1..15)
//
// state  | meaning
// -------+-----------------------------------------------------------
// HALTED | idle after reset, waiting for Run
// FETCH1 | PC onto bus, MAR<-PC, PC<-PC+1
// FETCH2 | SRAM read, MEM_WAIT cycles; MDR loads on the last one
// FETCH3 | MDR onto bus, IR<-MDR
// PAUSE1 | waiting for Continue to rise
// PAUSE2 | waiting for Continue to fall, then fetch again
module isdu_fetch_ctrl #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  output logic       load_mar,
  output logic       load_pc,
  output logic       load_mdr,
  output logic       load_ir,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       Mem_CE,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    FETCH3 = 3'd3,
    PAUSE1 = 3'd4,
    PAUSE2 = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     state;
  logic [3:0] wait_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
    end else begin
      case (state)
        HALTED: if (Run) state <= FETCH1;
        FETCH1: begin
          state    <= FETCH2;
          wait_cnt <= '0;
        end
        FETCH2: begin
          // Counts up through the read; with MEM_WAIT=15 it stops at 15,
          // so the 4-bit counter never wraps.
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) state <= FETCH3;
        end
        FETCH3: state <= PAUSE1;
        PAUSE1: if (Continue) state <= PAUSE2;
        PAUSE2: if (!Continue) state <= FETCH1;
        default: state <= HALTED;
      endcase
    end
  end

  // Moore decode from state and wait_cnt only. Reset clears the state
  // asynchronously, so the strobes go idle without waiting for an edge.
  always_comb begin
    load_mar = 1'b0;
    load_pc  = 1'b0;
    load_mdr = 1'b0;
    load_ir  = 1'b0;
    GatePC   = 1'b0;
    GateMDR  = 1'b0;
    Mem_CE   = 1'b1;
    Mem_OE   = 1'b1;
    case (state)
      FETCH1: begin
        GatePC   = 1'b1;
        load_mar = 1'b1;
        load_pc  = 1'b1;
      end
      FETCH2: begin
        Mem_CE   = 1'b0;
        Mem_OE   = 1'b0;
        load_mdr = (wait_cnt == WAIT_LAST);
      end
      FETCH3: begin
        GateMDR = 1'b1;
        load_ir = 1'b1;
      end
      default: ;
    endcase
  end

  assign Mem_WE    = 1'b1;
  assign state_dbg = state;

endmodule

// File: tb/tb_isdu_fetch_ctrl.sv
module tb_isdu_fetch_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  logic Continue = 1'b0;

  // index 0: MEM_WAIT=2 instance, index 1: MEM_WAIT=1 instance
  logic [1:0] load_mar, load_pc, load_mdr, load_ir, GatePC, GateMDR;
  logic [1:0] Mem_CE, Mem_OE, Mem_WE;
  logic [2:0] state_dbg [2];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 halted, 1 fetching (k = cycle offset in the
  // fetch), 2 waiting for press, 3 waiting for release.
  int mode [2];
  int k    [2];
  int mw   [2] = '{2, 1};

  isdu_fetch_ctrl #(.MEM_WAIT(2)) dut_w2 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .load_mar(load_mar[0]), .load_pc(load_pc[0]), .load_mdr(load_mdr[0]),
    .load_ir(load_ir[0]), .GatePC(GatePC[0]), .GateMDR(GateMDR[0]),
    .Mem_CE(Mem_CE[0]), .Mem_OE(Mem_OE[0]), .Mem_WE(Mem_WE[0]),
    .state_dbg(state_dbg[0])
  );

  isdu_fetch_ctrl #(.MEM_WAIT(1)) dut_w1 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .load_mar(load_mar[1]), .load_pc(load_pc[1]), .load_mdr(load_mdr[1]),
    .load_ir(load_ir[1]), .GatePC(GatePC[1]), .GateMDR(GateMDR[1]),
    .Mem_CE(Mem_CE[1]), .Mem_OE(Mem_OE[1]), .Mem_WE(Mem_WE[1]),
    .state_dbg(state_dbg[1])
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // {load_mar, load_pc, load_mdr, load_ir, GatePC, GateMDR, CE, OE, WE, state_dbg}
  function automatic logic [11:0] observed(int i);
    return {load_mar[i], load_pc[i], load_mdr[i], load_ir[i], GatePC[i],
            GateMDR[i], Mem_CE[i], Mem_OE[i], Mem_WE[i], state_dbg[i]};
  endfunction

  function automatic logic [11:0] expected(int i);
    logic [11:0] e;
    e = {9'b000000111, 3'd0};
    if (mode[i] == 2) e[2:0] = 3'd4;
    else if (mode[i] == 3) e[2:0] = 3'd5;
    else if (mode[i] == 1) begin
      if (k[i] == 0)
        e = {9'b110010111, 3'd1};
      else if (k[i] <= mw[i])
        e = {1'b0, 1'b0, 1'(k[i] == mw[i]), 6'b000001, 3'd2};
      else
        e = {9'b000101111, 3'd3};
    end
    return e;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        mode[i] = 0; k[i] = 0;
      end else begin
        case (mode[i])
          0: if (Run) begin mode[i] = 1; k[i] = 0; end
          1: begin
            k[i]++;
            if (k[i] > mw[i] + 1) mode[i] = 2;
          end
          2: if (Continue) mode[i] = 3;
          default: if (!Continue) begin mode[i] = 1; k[i] = 0; end
        endcase
      end
    end
  endtask

  task automatic model_async_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; k[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_w2"}, 32'(observed(0)), 32'(expected(0)));
    chk({tag, "_w1"}, 32'(observed(1)), 32'(expected(1)));
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_all(tag);
  endtask

  // Bus-ownership invariants, sampled every cycle on the falling edge.
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("inv_gate_excl", 32'(GatePC[i] & GateMDR[i]), 32'd0);
      chk("inv_gate_vs_oe", 32'((GatePC[i] | GateMDR[i]) & ~Mem_OE[i]), 32'd0);
      chk("inv_we_high", 32'(Mem_WE[i]), 32'd1);
    end
  end

  initial begin
    int mar_cnt;
    int ir_cnt;
    model_async_reset();

    // Reset held for 10 cycles with Run=Continue=0.
    @(negedge Clk);
    check_all("reset");
    for (int c = 0; c < 10; c++) tick("reset_hold");

    // Single fetch from Run.
    Reset = 1'b0;
    Run   = 1'b1;
    tick("fetch_c1");
    Run = 1'b0;
    for (int c = 2; c <= 6; c++) tick("fetch_seq");
    chk("pause_state_w2", 32'(state_dbg[0]), 32'd4);

    // Continue held high for 20 cycles: no fetch until it falls.
    Continue = 1'b1;
    mar_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick("cont_hold");
      mar_cnt += load_mar[0];
    end
    chk("cont_hold_no_fetch", 32'(mar_cnt), 32'd0);
    Continue = 1'b0;
    tick("cont_fall");
    chk("fetch1_after_fall", 32'(load_mar[0]), 32'd1);
    mar_cnt = 1;
    ir_cnt  = 0;
    for (int c = 0; c < 10; c++) begin
      tick("cont_after");
      mar_cnt += load_mar[0];
      ir_cnt  += load_ir[0];
    end
    chk("one_fetch1_per_press", 32'(mar_cnt), 32'd1);
    chk("one_load_ir_per_press", 32'(ir_cnt), 32'd1);

    // Short press, then async reset in the first FETCH2 cycle.
    Continue = 1'b1;
    tick("press");
    Continue = 1'b0;
    tick("release");
    tick("into_fetch2");
    chk("fetch2_oe_low", 32'(Mem_OE[0]), 32'd0);
    chk("w1_mdr_high", 32'(load_mdr[1]), 32'd1);
    Reset = 1'b1;
    #1;
    model_async_reset();
    chk("async_oe_w2", 32'(Mem_OE[0]), 32'd1);
    chk("async_oe_w1", 32'(Mem_OE[1]), 32'd1);
    chk("async_mdr_w1", 32'(load_mdr[1]), 32'd0);
    check_all("async_reset");
    tick("reset_held");
    Reset = 1'b0;
    Run   = 1'b1;
    tick("restart");
    chk("restart_fetch1", 32'(state_dbg[0]), 32'd1);
    Run = 1'b0;

    // Randomized stimulus against the model.
    for (int c = 0; c < 800; c++) begin
      Run = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) Continue = ~Continue;
      if (Reset) begin
        if ($urandom_range(0, 1) == 0) Reset = 1'b0;
      end else if ($urandom_range(0, 49) == 0) begin
        #2;
        Reset = 1'b1;
        #1;
        model_async_reset();
        check_all("rand_async");
      end
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
